cache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate cache controller with one 32-bit word per line. It sequences the team's CacheRAM data store and keeps the tag, valid and dirty state in internal registers. It sits between one CPU-side requester and a single-beat memory bus, and it serialises lookups, victim write-backs and refills onto the single-port-behaviour RAM. A write to the RAM suppresses the RAM read that cycle, and RAM read data is registered (1-cycle latency).

---
 rtl/cache_pkg.sv | 29 ++
 rtl/cache_tag_array.sv | 47 ++++
 rtl/cache_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types, field widths and the byte-merge helper for the cache controller.
package cache_pkg;

  localparam int OFFSET_BITS        = 2;
  localparam int ADDR_WIDTH_DEFAULT = 32;
  localparam int INDEX_BITS_DEFAULT = 5;
  localparam int TAG_BITS           = ADDR_WIDTH_DEFAULT - INDEX_BITS_DEFAULT - OFFSET_BITS;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_WB     = 3'd2,
    ST_REFILL = 3'd3,
    ST_FILL   = 3'd4
  } state_t;

  // Replace each byte of base whose enable is set with the matching byte of wdata.
  function automatic logic [31:0] byte_merge(input logic [31:0] base,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = base;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cache_tag_array.sv
// Per-line {valid, dirty, tag} store: asynchronous read, synchronous write.
// Valid and dirty clear on reset; tags are meaningless while valid is low.
module cache_tag_array
  import cache_pkg::*;
#(
  parameter int INDEX_BITS = 5,
  parameter int TAG_W      = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic                  wr_dirty,
  input  logic [TAG_W-1:0]      wr_tag
);

  localparam int DEPTH = 1 << INDEX_BITS;

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q [DEPTH];

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];

  // Status bits: cleared by reset, any write marks the line valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
      dirty_q[wr_index] <= wr_dirty;
    end
  end

  // Tag storage needs no reset because valid gates every use.
  always_ff @(posedge clk) begin
    if (wr_en) tag_q[wr_index] <= wr_tag;
  end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate controller, one word per line.
// Sequences the external data RAM (registered read) and a single-beat memory bus.
//
// state  | meaning
// IDLE   | ready for a CPU request; RAM read address follows cpu_addr
// LOOKUP | RAM word and tag available; complete hit or classify miss
// WB     | writing dirty victim to memory, waiting for mem_ack
// REFILL | reading the requested word from memory, waiting for mem_ack
// FILL   | writing merged refill word into RAM and completing the request
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [3:0]            cpu_be,
  output logic                  cpu_ready,
  output logic                  cpu_valid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  ram_wr_en,
  output logic [INDEX_BITS-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [3:0]            ram_wr_byte_en,
  output logic [INDEX_BITS-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                            state;
  logic                              req_we;
  logic [ADDR_WIDTH-1:OFFSET_BITS]   req_word;
  logic [DATA_WIDTH-1:0]             req_wdata;
  logic [3:0]                        req_be;
  logic [ADDR_WIDTH-1:0]             victim_addr;
  logic [DATA_WIDTH-1:0]             victim_data;
  logic [DATA_WIDTH-1:0]             refill_data;

  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_BITS-1:0] cpu_index;
  logic                  ent_valid;
  logic                  ent_dirty;
  logic [TAG_W-1:0]      ent_tag;
  logic                  lookup_hit;
  logic [DATA_WIDTH-1:0] hit_word;
  logic [DATA_WIDTH-1:0] fill_word;
  logic                  tag_wr_en;
  logic                  tag_wr_dirty;
  logic                  unused_offset;

  assign req_index     = req_word[INDEX_BITS+1:OFFSET_BITS];
  assign req_tag       = req_word[ADDR_WIDTH-1:INDEX_BITS+OFFSET_BITS];
  assign cpu_index     = cpu_addr[INDEX_BITS+1:OFFSET_BITS];
  assign unused_offset = ^cpu_addr[OFFSET_BITS-1:0];

  assign lookup_hit = ent_valid && (ent_tag == req_tag);
  assign hit_word   = byte_merge(ram_rd_data, req_wdata, req_be);
  // A read miss keeps the refill word untouched.
  assign fill_word  = byte_merge(refill_data, req_wdata, req_we ? req_be : 4'b0000);

  cache_tag_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_tags (
    .clk      (clk),
    .rst      (rst),
    .rd_index (req_index),
    .rd_valid (ent_valid),
    .rd_dirty (ent_dirty),
    .rd_tag   (ent_tag),
    .wr_en    (tag_wr_en),
    .wr_index (req_index),
    .wr_dirty (tag_wr_dirty),
    .wr_tag   (req_tag)
  );

  // State sequencing, request/victim/refill capture and saturating statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      req_we      <= 1'b0;
      req_word    <= '0;
      req_wdata   <= '0;
      req_be      <= '0;
      victim_addr <= '0;
      victim_data <= '0;
      refill_data <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_word  <= cpu_addr[ADDR_WIDTH-1:OFFSET_BITS];
            req_wdata <= cpu_wdata;
            req_be    <= cpu_be;
            state     <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (lookup_hit) begin
            if (hit_count != '1) hit_count <= hit_count + CNT_ONE;
            state <= ST_IDLE;
          end else begin
            if (miss_count != '1) miss_count <= miss_count + CNT_ONE;
            if (ent_valid && ent_dirty) begin
              victim_addr <= {ent_tag, req_index, {OFFSET_BITS{1'b0}}};
              victim_data <= ram_rd_data;
              state       <= ST_WB;
            end else begin
              state <= ST_REFILL;
            end
          end
        end
        ST_WB: begin
          if (mem_ack) state <= ST_REFILL;
        end
        ST_REFILL: begin
          if (mem_ack) begin
            refill_data <= mem_rdata;
            state       <= ST_FILL;
          end
        end
        ST_FILL: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output decode; LOOKUP outputs depend on the freshly read RAM word and tag.
  always_comb begin
    cpu_ready      = 1'b0;
    cpu_valid      = 1'b0;
    cpu_rdata      = '0;
    ram_wr_en      = 1'b0;
    ram_wr_addr    = '0;
    ram_wr_data    = '0;
    ram_wr_byte_en = '0;
    ram_rd_addr    = req_index;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    tag_wr_en      = 1'b0;
    tag_wr_dirty   = 1'b0;
    case (state)
      ST_IDLE: begin
        cpu_ready   = 1'b1;
        ram_rd_addr = cpu_index;
      end
      ST_LOOKUP: begin
        if (lookup_hit) begin
          cpu_valid = 1'b1;
          cpu_rdata = req_we ? hit_word : ram_rd_data;
          if (req_we) begin
            ram_wr_en      = 1'b1;
            ram_wr_addr    = req_index;
            ram_wr_data    = req_wdata;
            ram_wr_byte_en = req_be;
            tag_wr_en      = 1'b1;
            tag_wr_dirty   = 1'b1;
          end
        end
      end
      ST_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = victim_addr;
        mem_wdata = victim_data;
      end
      ST_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_word, {OFFSET_BITS{1'b0}}};
      end
      ST_FILL: begin
        cpu_valid      = 1'b1;
        cpu_rdata      = fill_word;
        ram_wr_en      = 1'b1;
        ram_wr_addr    = req_index;
        ram_wr_data    = fill_word;
        ram_wr_byte_en = 4'b1111;
        tag_wr_en      = 1'b1;
        tag_wr_dirty   = req_we;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: data RAM and memory models, a line-level
// cache model producing expectations, and one compare process.
module tb_cache_ctrl;

  localparam int AW = 32;
  localparam int IB = 5;
  localparam int DW = 32;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [3:0]    cpu_be;
  logic          cpu_ready, cpu_valid;
  logic [DW-1:0] cpu_rdata;
  logic          ram_wr_en;
  logic [IB-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data;
  logic [3:0]    ram_wr_byte_en;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [CW-1:0] hit_count, miss_count;

  logic resp_ack = 1'b0;
  logic late_ack = 1'b0;
  logic hold     = 1'b0;
  assign mem_ack = resp_ack | late_ack;

  always #5 clk = ~clk;

  cache_ctrl #(.ADDR_WIDTH(AW), .INDEX_BITS(IB), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_ready(cpu_ready), .cpu_valid(cpu_valid),
    .cpu_rdata(cpu_rdata), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .ram_wr_byte_en(ram_wr_byte_en), .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_msg(input string name);
    checks++;
    failures++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  // Data RAM model: byte-enabled write, registered read suppressed by a write, clears on reset.
  logic [31:0] bram [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) bram[i] <= '0;
      ram_rd_data <= '0;
    end else if (ram_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_wr_byte_en[b]) bram[ram_wr_addr][8*b +: 8] <= ram_wr_data[8*b +: 8];
    end else begin
      ram_rd_data <= bram[ram_rd_addr];
    end
  end

  // Memory responder: acks after three cycles of mem_req unless held.
  logic [31:0] resp_mem [logic [31:0]];
  initial begin
    int wcnt = 0;
    forever begin
      @(negedge clk);
      if (resp_ack) resp_ack = 1'b0;
      else if (rst) wcnt = 0;
      else if (mem_req && !hold) begin
        if (wcnt >= 2) begin
          resp_ack = 1'b1;
          wcnt = 0;
          if (mem_we) resp_mem[mem_addr] = mem_wdata;
          else mem_rdata = resp_mem.exists(mem_addr) ? resp_mem[mem_addr] : 32'h0;
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  // Line-level model of the cache.
  typedef struct {logic [31:0] rdata; bit chk_rd; int hits; int misses;} cpu_exp_t;
  typedef struct {bit we; logic [31:0] addr; logic [31:0] wdata;} mem_exp_t;
  typedef struct {logic [4:0] idx; logic [3:0] be; logic [31:0] data;} ram_exp_t;

  cpu_exp_t exp_cpu[$];
  mem_exp_t exp_mem[$];
  ram_exp_t exp_ram[$];

  bit          m_valid [32];
  bit          m_dirty [32];
  logic [24:0] m_tag   [32];
  logic [31:0] m_data  [32];
  logic [31:0] model_mem [logic [31:0]];
  int          m_hits, m_misses;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    return (nw & be_mask(be)) | (old & ~be_mask(be));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits = 0;
    m_misses = 0;
    exp_cpu.delete();
    exp_mem.delete();
    exp_ram.delete();
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    resp_mem[a]  = d;
    model_mem[a] = d;
  endtask

  task automatic model_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] be, output bit hit);
    logic [4:0]  idx;
    logic [24:0] tg;
    logic [31:0] waddr, w;
    cpu_exp_t ce;
    mem_exp_t me;
    ram_exp_t re;
    idx   = addr[6:2];
    tg    = addr[31:7];
    waddr = {addr[31:2], 2'b00};
    hit   = m_valid[idx] && (m_tag[idx] == tg);
    if (hit) begin
      if (m_hits < CMAX) m_hits++;
      if (we) begin
        m_data[idx]  = merge(m_data[idx], wd, be);
        m_dirty[idx] = 1'b1;
        re.idx = idx; re.be = be; re.data = wd;
        exp_ram.push_back(re);
      end
    end else begin
      if (m_misses < CMAX) m_misses++;
      if (m_valid[idx] && m_dirty[idx]) begin
        me.we = 1'b1; me.addr = {m_tag[idx], idx, 2'b00}; me.wdata = m_data[idx];
        exp_mem.push_back(me);
        model_mem[me.addr] = m_data[idx];
      end
      me.we = 1'b0; me.addr = waddr; me.wdata = 32'h0;
      exp_mem.push_back(me);
      w = model_mem.exists(waddr) ? model_mem[waddr] : 32'h0;
      if (we) w = merge(w, wd, be);
      m_data[idx]  = w;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = we;
      m_tag[idx]   = tg;
      re.idx = idx; re.be = 4'hF; re.data = w;
      exp_ram.push_back(re);
    end
    ce.rdata  = m_data[idx];
    ce.chk_rd = !(hit && we);
    ce.hits   = m_hits;
    ce.misses = m_misses;
    exp_cpu.push_back(ce);
  endtask

  // Compare process, sampled just after the falling edge.
  logic [31:0] last_wb_addr = '0, last_wb_data = '0, last_ram_data = '0;
  logic [3:0]  last_ram_be = '0;
  initial begin
    bit       prev_req = 1'b0;
    bit       cnt_pending = 1'b0;
    cpu_exp_t ce, cnt_exp;
    mem_exp_t me;
    ram_exp_t re;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we;
    cnt_exp = '{32'h0, 1'b0, 0, 0};
    cap_addr = '0; cap_wdata = '0; cap_we = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_req = 1'b0;
        cnt_pending = 1'b0;
      end else begin
        if (cnt_pending) begin
          check("hit_count", 32'(hit_count), 32'(cnt_exp.hits));
          check("miss_count", 32'(miss_count), 32'(cnt_exp.misses));
          cnt_pending = 1'b0;
        end
        if (cpu_valid) begin
          if (exp_cpu.size() == 0) fail_msg("unexpected_cpu_valid");
          else begin
            ce = exp_cpu.pop_front();
            if (ce.chk_rd) check("cpu_rdata", cpu_rdata, ce.rdata);
            cnt_exp = ce;
            cnt_pending = 1'b1;
          end
        end
        if (ram_wr_en) begin
          check("ram_wr_while_ready", 32'(cpu_ready), 32'd0);
          if (exp_ram.size() == 0) fail_msg("unexpected_ram_wr");
          else begin
            re = exp_ram.pop_front();
            check("ram_wr_addr", 32'(ram_wr_addr), 32'(re.idx));
            check("ram_wr_byte_en", 32'(ram_wr_byte_en), 32'(re.be));
            check("ram_wr_data", ram_wr_data & be_mask(re.be), re.data & be_mask(re.be));
            last_ram_data = ram_wr_data;
            last_ram_be   = ram_wr_byte_en;
          end
        end
        if (mem_req) begin
          if (!prev_req) begin
            if (exp_mem.size() == 0) fail_msg("unexpected_mem_req");
            else begin
              me = exp_mem.pop_front();
              check("mem_we", 32'(mem_we), 32'(me.we));
              check("mem_addr", mem_addr, me.addr);
              if (me.we) begin
                check("mem_wdata", mem_wdata, me.wdata);
                last_wb_addr = mem_addr;
                last_wb_data = mem_wdata;
              end
            end
            cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata;
          end else begin
            check("mem_addr_stable", mem_addr, cap_addr);
            check("mem_we_stable", 32'(mem_we), 32'(cap_we));
            check("mem_wdata_stable", mem_wdata, cap_wdata);
          end
        end
        prev_req = mem_req && !mem_ack;
      end
    end
  end

  // Present a request at a falling edge and hold it until accepted.
  task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, output bit hit);
    int t = 0;
    model_access(we, addr, wd, be, hit);
    while (!cpu_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!cpu_ready) fail_msg("timeout_cpu_ready");
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_be = be; cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  task automatic wait_done(input bit hit, input bit chk_lat, output logic [31:0] rd);
    int k = 1;
    while (!cpu_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    rd = cpu_rdata;
    if (!cpu_valid) fail_msg("timeout_cpu_valid");
    else if (chk_lat) begin
      if (hit) check("hit_latency", 32'(k), 32'd1);
      else if (k < 3) fail_msg("miss_latency_too_short");
    end
    @(negedge clk);
  endtask

  task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be, output logic [31:0] rd);
    bit hit;
    issue(we, addr, wd, be, hit);
    wait_done(hit, 1'b1, rd);
  endtask

  task automatic wait_mem_req();
    int t = 0;
    while (!mem_req && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!mem_req) fail_msg("timeout_mem_req");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog_expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit          hit;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    preload(32'h40,  32'hDEADBEEF);
    preload(32'hC0,  32'h0C0C0C0C);
    preload(32'h80,  32'h0000FFFF);
    preload(32'h180, 32'h18018018);
    preload(32'h200, 32'h22222222);
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_cpu_ready", 32'(cpu_ready), 32'd1);
    check("rst_cpu_valid", 32'(cpu_valid), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_ram_wr_en", 32'(ram_wr_en), 32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_miss_count", 32'(miss_count), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_access(1'b0, 32'h40, 32'h0, 4'h0, rd);
    check("t1_refill_data", rd, 32'hDEADBEEF);
    do_access(1'b0, 32'h40, 32'h0, 4'h0, rd);
    check("t1_hit_data", rd, 32'hDEADBEEF);
    check("t1_hits", 32'(hit_count), 32'd1);
    check("t1_misses", 32'(miss_count), 32'd1);

    do_access(1'b1, 32'h40, 32'h000000AA, 4'b0001, rd);
    check("t2_wr_hit_be", 32'(last_ram_be), 32'h1);
    do_access(1'b0, 32'h40, 32'h0, 4'h0, rd);
    check("t2_read_after_wr", rd, 32'hDEADBEAA);

    do_access(1'b0, 32'hC0, 32'h0, 4'h0, rd);
    check("t3_wb_addr", last_wb_addr, 32'h40);
    check("t3_wb_data", last_wb_data, 32'hDEADBEAA);
    check("t3_refill", rd, 32'h0C0C0C0C);

    do_access(1'b1, 32'h80, 32'h12340000, 4'b1100, rd);
    check("t4_merged", rd, 32'h1234FFFF);
    check("t4_ram_data", last_ram_data, 32'h1234FFFF);
    do_access(1'b0, 32'h180, 32'h0, 4'h0, rd);
    check("t4_wb_addr", last_wb_addr, 32'h80);
    check("t4_wb_data", last_wb_data, 32'h1234FFFF);

    hold = 1'b1;
    issue(1'b0, 32'h40, 32'h0, 4'h0, hit);
    wait_mem_req();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cpu_req = ~cpu_req;
      cpu_addr = 32'h300;
      check("hold_cpu_ready", 32'(cpu_ready), 32'd0);
      check("hold_mem_req", 32'(mem_req), 32'd1);
    end
    cpu_req = 1'b0;
    hold = 1'b0;
    wait_done(hit, 1'b0, rd);
    check("t5_data", rd, 32'hDEADBEAA);

    hold = 1'b1;
    issue(1'b0, 32'h200, 32'h0, 4'h0, hit);
    wait_mem_req();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    hold = 1'b0;
    check("mid_rst_mem_req", 32'(mem_req), 32'd0);
    check("mid_rst_ready", 32'(cpu_ready), 32'd1);
    late_ack = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("late_ack_valid", 32'(cpu_valid), 32'd0);
      check("late_ack_mem_req", 32'(mem_req), 32'd0);
      check("late_ack_ready", 32'(cpu_ready), 32'd1);
      @(negedge clk);
    end

    do_access(1'b0, 32'h40, 32'h0, 4'h0, rd);
    check("t6_miss_data", rd, 32'hDEADBEAA);
    check("t6_hits", 32'(hit_count), 32'd0);
    check("t6_misses", 32'(miss_count), 32'd1);

    do_access(1'b1, 32'h40, 32'h55AA55AA, 4'hF, rd);
    do_access(1'b0, 32'h40, 32'h0, 4'h0, rd);
    check("t7_b2b_read", rd, 32'h55AA55AA);
    for (int i = 0; i < 6; i++) do_access(1'b0, 32'h40, 32'h0, 4'h0, rd);
    check("t7_hit_sat", 32'(hit_count), 32'd7);

    do_access(1'b0, 32'hC0, 32'h0, 4'h0, rd);
    check("t8_wb_data", last_wb_data, 32'h55AA55AA);
    for (int i = 0; i < 7; i++)
      do_access(1'b0, (i % 2 == 0) ? 32'h40 : 32'hC0, 32'h0, 4'h0, rd);
    check("t8_miss_sat", 32'(miss_count), 32'd7);
    check("t8_hit_hold", 32'(hit_count), 32'd7);

    repeat (2) @(negedge clk);
    check("left_cpu_exp", 32'(exp_cpu.size()), 32'd0);
    check("left_mem_exp", 32'(exp_mem.size()), 32'd0);
    check("left_ram_exp", 32'(exp_ram.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
